issue_hazard_ctrl: RTL

ISSUE_HAZARD_CTRL -- requirements
Module: issue_hazard_ctrl

---
 rtl/issue_hazard_ctrl_pkg.sv | 14 +
 rtl/hazard_src_match.sv | 25 ++
 rtl/issue_hazard_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/issue_hazard_ctrl_pkg.sv
// Shared hazard-control definitions: FSM states, register-file width, r0 id.
package issue_hazard_ctrl_pkg;

    localparam int REG_BITS_DEF = 3;
    localparam int R0           = 0;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_SPLIT,
        ST_FLUSH,
        ST_MEMWAIT
    } hz_state_e;

endpackage

// File: rtl/hazard_src_match.sv
// Destination-vs-source comparator with r0 and per-source valid masking.
module hazard_src_match
    import issue_hazard_ctrl_pkg::*;
#(
    parameter int REG_BITS = REG_BITS_DEF,
    parameter int NUM_SRC  = 4
) (
    input  logic [REG_BITS-1:0]              dst,
    input  logic                             dst_en,
    input  logic [NUM_SRC-1:0][REG_BITS-1:0] src,
    input  logic [NUM_SRC-1:0]               src_vld,
    output logic                             hit
);

    logic [NUM_SRC-1:0] eq;

    // One equality per source; masked sources never match.
    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        assign eq[g] = src_vld[g] && (src[g] == dst);
    end

    // r0 is hard-wired zero, so writing it never creates a dependency.
    assign hit = dst_en && (dst != REG_BITS'(R0)) && (|eq);

endmodule

// File: rtl/issue_hazard_ctrl.sv
// Dual-issue hazard controller: load-use stall, intra-pair split,
// branch flush and memory-wait hold, plus a saturating stall counter.
module issue_hazard_ctrl
    import issue_hazard_ctrl_pkg::*;
#(
    parameter int REG_BITS     = REG_BITS_DEF,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [REG_BITS-1:0] IF_ID_rm_1,
    input  logic [REG_BITS-1:0] IF_ID_rn_1,
    input  logic [REG_BITS-1:0] IF_ID_rm_2,
    input  logic [REG_BITS-1:0] IF_ID_rn_2,
    input  logic [REG_BITS-1:0] IF_ID_rd_1,
    input  logic                IF_ID_RegWrite1,
    input  logic                IF_ID_Valid2,
    input  logic                ID_EX_MemRead2,
    input  logic [REG_BITS-1:0] ID_EX_rd_2,
    input  logic                Branch_Taken,
    input  logic                Mem_Ready,
    output logic                PC_Write,
    output logic                IF_ID_Write,
    output logic                ID_EX_Bubble1,
    output logic                ID_EX_Bubble2,
    output logic                IF_ID_Flush,
    output logic                Pipe_Hold,
    output logic [CNT_W-1:0]    Stall_Count
);

    localparam logic [3:0] FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);

    hz_state_e  state, nxt_state, ret_state, nxt_ret, eff_state;
    logic [3:0] flush_cnt, nxt_flush_cnt;
    logic       ld_use, split, pipe1_chk;
    logic       pc_w, ifid_w, bub1, bub2, flush, hold;

    // While waiting on memory, decode as the state we will return to.
    assign eff_state = (state == ST_MEMWAIT) ? ret_state : state;

    // In SPLIT pipe-1 has already left decode, so only pipe-2 sources matter.
    assign pipe1_chk = (eff_state != ST_SPLIT);

    hazard_src_match #(.REG_BITS(REG_BITS), .NUM_SRC(4)) u_ld_use (
        .dst     (ID_EX_rd_2),
        .dst_en  (ID_EX_MemRead2),
        .src     ({IF_ID_rn_2, IF_ID_rm_2, IF_ID_rn_1, IF_ID_rm_1}),
        .src_vld ({IF_ID_Valid2, IF_ID_Valid2, pipe1_chk, pipe1_chk}),
        .hit     (ld_use)
    );

    hazard_src_match #(.REG_BITS(REG_BITS), .NUM_SRC(2)) u_split (
        .dst     (IF_ID_rd_1),
        .dst_en  (IF_ID_Valid2 && IF_ID_RegWrite1),
        .src     ({IF_ID_rn_2, IF_ID_rm_2}),
        .src_vld (2'b11),
        .hit     (split)
    );

    // State, return-state and flush-counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_RUN;
            ret_state <= ST_RUN;
            flush_cnt <= '0;
        end else begin
            state     <= nxt_state;
            ret_state <= nxt_ret;
            flush_cnt <= nxt_flush_cnt;
        end
    end

    // Next-state and Mealy outputs, highest-priority condition first.
    always_comb begin
        nxt_state     = ST_RUN;
        nxt_ret       = ret_state;
        nxt_flush_cnt = flush_cnt;
        pc_w          = 1'b1;
        ifid_w        = 1'b1;
        bub1          = 1'b0;
        bub2          = 1'b0;
        flush         = 1'b0;
        hold          = 1'b0;
        if (!Mem_Ready) begin
            hold      = 1'b1;
            pc_w      = 1'b0;
            ifid_w    = 1'b0;
            nxt_state = ST_MEMWAIT;
            nxt_ret   = eff_state;
        end else if (Branch_Taken) begin
            flush = 1'b1;
            bub1  = 1'b1;
            bub2  = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                nxt_state     = ST_FLUSH;
                nxt_flush_cnt = FLUSH_RELOAD;
            end else begin
                nxt_flush_cnt = '0;
            end
        end else begin
            case (eff_state)
                ST_FLUSH: begin
                    flush         = 1'b1;
                    bub1          = 1'b1;
                    bub2          = 1'b1;
                    nxt_flush_cnt = flush_cnt - 4'd1;
                    nxt_state     = (flush_cnt <= 4'd1) ? ST_RUN : ST_FLUSH;
                end
                ST_SPLIT: begin
                    if (ld_use) begin
                        pc_w      = 1'b0;
                        ifid_w    = 1'b0;
                        bub1      = 1'b1;
                        bub2      = 1'b1;
                        nxt_state = ST_SPLIT;
                    end else begin
                        bub1 = 1'b1;
                    end
                end
                default: begin
                    if (ld_use) begin
                        pc_w   = 1'b0;
                        ifid_w = 1'b0;
                        bub1   = 1'b1;
                        bub2   = 1'b1;
                    end else if (split) begin
                        pc_w      = 1'b0;
                        ifid_w    = 1'b0;
                        bub2      = 1'b1;
                        nxt_state = ST_SPLIT;
                    end
                end
            endcase
        end
    end

    // Saturating count of cycles in which the PC did not advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            Stall_Count <= '0;
        else if (!pc_w && (Stall_Count != {CNT_W{1'b1}}))
            Stall_Count <= Stall_Count + 1'b1;
    end

    // Reset forces a safe freeze: PC held and both EX slots bubbled.
    assign PC_Write      = rst_n & pc_w;
    assign IF_ID_Write   = rst_n & ifid_w;
    assign ID_EX_Bubble1 = ~rst_n | bub1;
    assign ID_EX_Bubble2 = ~rst_n | bub2;
    assign IF_ID_Flush   = rst_n & flush;
    assign Pipe_Hold     = rst_n & hold;

endmodule
